// File: rtl/jk_register_if.sv
// Bus bundle for jk_register: control/data inputs and state/flag outputs.
interface jk_register_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] d;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic             tc;
  logic             changed;

  modport master (
    output en, mode, j, k, d, ser_in,
    input  q, q_n, tc, changed
  );

  modport slave (
    input  en, mode, j, k, d, ser_in,
    output q, q_n, tc, changed
  );
endinterface

// File: rtl/jk_register.sv
// Parametrised multi-bit JK register with LOAD, SHIFT and COUNT modes,
// asynchronous active-low reset and preset (reset wins), a registered change
// flag and a combinational count terminal flag.
// Optional feature macro: JK_REGISTER_SHIFT_EN enables SHIFT mode; when it is
// undefined, mode 2'b10 holds state and ser_in is ignored.
module jk_register #(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] PRESET_VALUE = {WIDTH{1'b1}}
) (
  input logic          clk,
  input logic          rst_n,
  input logic          preset_n,
  jk_register_if.slave bus
);

  typedef enum logic [1:0] {
    ModeJk    = 2'b00,
    ModeLoad  = 2'b01,
    ModeShift = 2'b10,
    ModeCount = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic             changed_q, changed_d;

`ifndef JK_REGISTER_SHIFT_EN
  // Serial input has no consumer when shifting is compiled out.
  logic unused_ser_in;
  assign unused_ser_in = bus.ser_in;
`endif

  // Next-state selection by mode; en low or an absent mode holds.
  always_comb begin
    q_d = q_q;
    if (bus.en) begin
      case (bus.mode)
        ModeJk:    q_d = (bus.j & ~q_q) | (~bus.k & q_q);
        ModeLoad:  q_d = bus.d;
`ifdef JK_REGISTER_SHIFT_EN
        ModeShift: q_d = {q_q[WIDTH-2:0], bus.ser_in};
`else
        ModeShift: q_d = q_q;
`endif
        ModeCount: q_d = q_q + WIDTH'(1);
        default:   q_d = q_q;
      endcase
    end
    changed_d = (q_d != q_q);
  end

  // State and change flag; reset beats preset, both override the clock.
  always_ff @(posedge clk or negedge rst_n or negedge preset_n) begin
    if (!rst_n) begin
      q_q       <= RESET_VALUE;
      changed_q <= 1'b0;
    end else if (!preset_n) begin
      q_q       <= PRESET_VALUE;
      changed_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      changed_q <= changed_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.q_n     = ~q_q;
  assign bus.changed = changed_q;
  // Combinational so a cascaded counter can act on the same edge.
  assign bus.tc      = bus.en & (bus.mode == ModeCount) & (&q_q);

endmodule

// File: doc/jk_register.md
# jk_register

Parametrised multi-bit JK register: the next generation of the single-bit JK flip-flop primitive in the sequential-logic library. It provides per-bit JK behaviour plus parallel-load, shift and binary-count modes, with async Reset and Preset. It also reports a registered change flag and a count terminal flag. It is the building block for control registers, small counters and serial converters.

## Interface
- WIDTH, 8: register width in bits (>= 2).
- RESET_VALUE, {WIDTH{1'b0}}: q value while Reset is asserted.
- PRESET_VALUE, {WIDTH{1'b1}}: q value while Preset is asserted.

Ports (clock and reset first):
- Clock  input  1  single clock; all state changes on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Preset  input  1  asynchronous, active-low preset; Reset has priority.
- en  input  1  synchronous enable; 0 = hold.
- mode  input  2  00 JK, 01 LOAD, 10 SHIFT, 11 COUNT.
- j  input  WIDTH  per-bit J.
- k  input  WIDTH  per-bit K.
- d  input  WIDTH  parallel load data.
- ser_in  input  1  serial input for SHIFT.
- q  output  WIDTH  register state.
- q_n  output  WIDTH  bitwise ~q, always complementary.
- tc  output  1  count terminal: combinational, en & mode==11 & (q == all ones).
- changed  output  1  registered; 1 for one cycle after an edge that altered q.

## Operation
- Async priority: Reset low -> q=RESET_VALUE, changed=0. Otherwise Preset low -> q=PRESET_VALUE, changed=0. Both low -> Reset wins.
- Release of either async input takes effect immediately. The next rising edge then acts normally.
- Rising edge, en=0: q holds and changed=0.
- Rising edge, en=1, per mode:
  - JK (00): each bit i is updated independently.
    - j=0, k=0: hold.
    - j=0, k=1: clear.
    - j=1, k=0: set.
    - j=1, k=1: toggle.
    - Equivalent next state: (j & ~q) | (~k & q).
  - LOAD (01): q <= d.
  - SHIFT (10): q <= {q[WIDTH-2:0], ser_in}. The MSB is discarded.
  - COUNT (11): q <= q + 1, modulo 2^WIDTH. All ones wraps to all zeros.
- j, k, d and ser_in are ignored outside their own mode.
- changed <= (next q != q) on every edge while not in async reset or preset.
- No illegal states: all mode encodings are defined.

## Timing
- Latency: one Clock edge from input sampling to new q. q_n follows q combinationally.
- tc is combinational from q, mode and en. It is valid in the same cycle as the state it describes, so a downstream counter can cascade on that edge.
- changed is registered. It is valid in the cycle following the altering edge.
- Async assertion mid-cycle overrides any pending update. No partial update is ever visible.

## Configuration
- JK_REGISTER_SHIFT_EN:
  - Defined: SHIFT mode (10) behaves as specified.
  - Undefined: mode 10 acts as hold, changed=0, and ser_in is unused. Synthesis drops the shift mux.

## Test plan
- WIDTH=8: Reset low -> q=0x00, q_n=0xFF, changed=0. Then Preset low with Reset high -> q=0xFF. Then both low -> q=0x00.
- JK mode, q=0xF0, j=0x3C, k=0xC3, en=1, one edge -> q=0x3C. changed=1 on the next cycle. A second edge with the same inputs -> q=0x3C, changed=0.
- JK mode, j=k=0xFF from q=0xA5 -> 0x5A, then 0xA5 on successive edges. Then en=0 with any inputs -> q holds at 0xA5, changed=0.
- COUNT mode from LOAD d=0xFE:
  - Edge 1 -> q=0xFF, tc=1.
  - Edge 2 -> q=0x00, tc=0.
  - Edge 3 -> q=0x01.
- SHIFT mode with JK_REGISTER_SHIFT_EN defined, q=0x81, ser_in=1 -> q=0x03, then ser_in=0 -> q=0x06. Without the macro, the same stimulus leaves q=0x81.
- Reset pulsed low mid-cycle during COUNT at q=0x10 -> q=0x00 immediately. After release, the first edge gives q=0x01.
